// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Two requesters share one 32-bit ALU. An idle arbiter grants one valid
// request in the same cycle (combinational ready). The result is registered
// at the accepting edge and held for the granted port until that port takes
// it. Then the arbiter returns to IDLE.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins simultaneous requests
//                                       (no pointer, GRANT_INIT unused)
//                          undefined -> round-robin pointer, reset to GRANT_INIT
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op  signed operands and opcode of requester N
//   rspN_valid / rspN_ready  response handshake for requester N
//   rsp_c, rsp_zero          registered result and its zero flag (shared)
//   busy                     high whenever the FSM is not in IDLE
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. reqN_ready may only be high in IDLE while rst is low.
// rspN_valid stays high until that edge and does not depend on rspN_ready.
// For a two-state FSM, busy is the state itself, so it doubles as the
// debug view of the FSM.
// ---------------------------------------------------------------------------

// Shared combinational ALU.
module alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] c_o
);
  always_comb begin
    c_o = 32'd0;
    unique case (op_i)
      3'b000: c_o = a_i;
      3'b001: c_o = a_i + b_i;
      3'b010: c_o = a_i - b_i;
      3'b011: c_o = a_i & b_i;
      3'b100: c_o = a_i | b_i;
      3'b101: c_o = {31'd0, $signed(a_i) < $signed(b_i)};
      3'b110: c_o = {31'd0, a_i < b_i};
      3'b111: c_o = 32'd0;
      default: c_o = 32'd0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter logic GRANT_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_zero,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // port that holds the current response
  logic [31:0] rsp_c_q;
  logic        rsp_zero_q;

  logic        grant_valid;
  logic        grant_port;
  logic        prio_port;          // port that wins a simultaneous request

  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_grant_init;
  assign unused_grant_init = GRANT_INIT;
  assign prio_port = 1'b0;
`else
  logic prio_q;
  assign prio_port = prio_q;
`endif

  // Grant decision: only in IDLE and never while reset is asserted.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_port  = prio_port;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_port;
  assign req1_ready = grant_valid &&  grant_port;

  // Operand steering into the single ALU.
  always_comb begin
    alu_a  = req0_a;
    alu_b  = req0_b;
    alu_op = req0_op;
    if (grant_port) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  alu u_alu (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .op_i (alu_op),
    .c_o  (alu_c)
  );

  // Next-state logic. The non-owner's rsp_ready is deliberately not looked at.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = RESP;
          owner_d = grant_port;
        end
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      rsp_c_q    <= 32'd0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (grant_valid) begin
        rsp_c_q    <= alu_c;
        rsp_zero_q <= (alu_c == 32'd0);
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // The pointer moves away from whichever port just won, including
  // when that port was the only requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= GRANT_INIT;
    end else if (grant_valid) begin
      prio_q <= ~grant_port;
    end
  end
`endif

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. The reference model keeps the arbiter's state as
// plain variables: whether a result is outstanding, its owner, the
// round-robin preference, the result value and the zero flag. It also keeps
// a queue of expected results. Directed sequences pin known values first.
// After that, a randomized phase drives every input, including occasional
// resets.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_c;
  logic        rsp_zero;
  logic        busy;

  alu_arbiter #(.GRANT_INIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_ready (rsp1_ready),
    .rsp_c      (rsp_c),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  // ---------------- check bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return a;
      3'd1: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd2: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  bit          model_on = 1'b0;
  bit          m_busy   = 1'b0;
  int          m_owner  = 0;
  int          m_prio   = 0;
  logic [31:0] m_c      = '0;
  logic        m_zero   = 1'b0;
  logic [31:0] exp_q[$];
  int          win;
  int          delivered = 0;
  logic [31:0] sb_e;

  always @(negedge clk) begin
    win = -1;
    if (!rst && !m_busy) begin
      if (req0_valid && req1_valid) win = FIXED ? 0 : m_prio;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    if (model_on) begin
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, win == 0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, win == 1});
      chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_busy && m_owner == 0});
      chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_busy && m_owner == 1});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      if (m_busy) begin
        chk("rsp_c", rsp_c, m_c);
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
        if (!rst && ((m_owner == 0) ? rsp0_ready : rsp1_ready)) begin
          chk("sb_nonempty", exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            chk("sb_result", rsp_c, sb_e);
          end
        end
      end
    end
    // Advance the model to what the coming edge must produce.
    if (rst) begin
      model_on = 1'b1;
      m_busy   = 1'b0;
      m_c      = '0;
      m_zero   = 1'b0;
      m_prio   = 0;
      exp_q.delete();
    end else if (win >= 0) begin
      m_busy  = 1'b1;
      m_owner = win;
      m_c     = (win == 0) ? alu_ref(req0_op, req0_a, req0_b) : alu_ref(req1_op, req1_a, req1_b);
      m_zero  = (m_c == 32'd0);
      m_prio  = 1 - win;
      exp_q.push_back(m_c);
    end else if (m_busy && ((m_owner == 0) ? rsp0_ready : rsp1_ready)) begin
      m_busy = 1'b0;
      delivered++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    idle_inputs();
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Issue one operation on a port and capture the result it delivers.
  // The task is entered just after a rising edge and returns just after one.
  task automatic run_op(input int port, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] c, output logic z);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    while (!got && n < 10) begin
      at_neg();
      if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
      step();
      n++;
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    at_neg();
    c = rsp_c;
    z = rsp_zero;
    if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] c_got;
  logic        z_got;
  int          g_port[$];
  int          g_cyc[$];
  int          exp_g[4];

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    // Reset with a request pending: ready must stay low throughout.
    req0_valid = 1'b1;
    rst        = 1'b1;
    step();
    at_neg();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp_c", rsp_c, 32'd0);
    step();
    rst        = 1'b0;
    req0_valid = 1'b0;
    at_neg();
    chk("busy_after_rst", {31'd0, busy}, 32'd0);

    // 7 + (-7) on port 0 wraps to zero.
    step();
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd7; req0_b = -32'sd7;
    at_neg();
    chk("add_ready0", {31'd0, req0_ready}, 32'd1);
    chk("add_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    at_neg();
    chk("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_rsp_c", rsp_c, 32'd0);
    chk("add_rsp_zero", {31'd0, rsp_zero}, 32'd1);
    step();
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // Unsigned FFFFFFFF < 1 is false; response held while ready is low.
    req1_valid = 1'b1; req1_op = 3'b110; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
    at_neg();
    chk("ult_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("hold_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("hold_rsp_c", rsp_c, 32'd0);
      step();
    end
    rsp1_ready = 1'b1;
    at_neg();
    chk("hs_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    step();
    rsp1_ready = 1'b0;
    at_neg();
    chk("drop_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    step();

    // Compare and constant-zero opcodes.
    run_op(0, 3'b101, 32'hFFFF_FFFF, 32'd1, c_got, z_got);
    chk("slt_c", c_got, 32'd1);
    run_op(1, 3'b110, 32'hFFFF_FFFF, 32'd1, c_got, z_got);
    chk("ult_c", c_got, 32'd0);
    run_op(0, 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, c_got, z_got);
    chk("zero_op_c", c_got, 32'd0);
    chk("zero_op_z", {31'd0, z_got}, 32'd1);
    run_op(1, 3'b010, 32'd3, 32'd10, c_got, z_got);
    chk("sub_wrap_c", c_got, 32'hFFFF_FFF9);

    // Arbitration with both ports requesting from a fresh reset.
    do_reset(2);
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd11;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'd22;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      if (req0_ready) begin g_port.push_back(0); g_cyc.push_back(i); end
      if (req1_ready) begin g_port.push_back(1); g_cyc.push_back(i); end
      step();
    end
    idle_inputs();
    exp_g = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
    chk("rr_count", g_port.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_port.size()) begin
        chk("rr_port", g_port[i], exp_g[i]);
        chk("rr_cycle", g_cyc[i], 2 * i);
      end
    end
    step();

    // Reset while port 0 holds a result: the result is discarded.
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd5; req0_b = 32'd0;
    step();
    req0_valid = 1'b0;
    at_neg();
    chk("pre_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    chk("post_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("post_rst_rsp_c", rsp_c, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      at_neg();
      chk("no_late_rsp0", {31'd0, rsp0_valid}, 32'd0);
    end
    step();
    rsp0_ready = 1'b0;

    // The other port's ready must not release port 0's response.
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd10; req0_b = 32'd3;
    rsp1_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("foreign_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("foreign_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      chk("foreign_rsp_c", rsp_c, 32'd7);
      step();
    end
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op    = 3'($urandom_range(0, 7));
      req1_op    = 3'($urandom_range(0, 7));
      req0_a     = rand_operand();
      req0_b     = rand_operand();
      req1_a     = rand_operand();
      req1_b     = rand_operand();
      rsp0_ready = ($urandom_range(0, 4) < 3);
      rsp1_ready = ($urandom_range(0, 4) < 3);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (4) step();
    at_neg();
    chk("final_idle", {31'd0, busy}, 32'd0);
    chk("delivered_some", {31'd0, delivered > 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter GRANT_INIT, default 1'b0, selecting the port that holds priority after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid and req1_valid  input  1 each  requester n presents an operation.
REQ-005 SHALL have ports req0_ready and req1_ready  output  1 each  operation of requester n accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b  input  32 each  signed operands of requester n.
REQ-007 SHALL have ports req0_op and req1_op  input  3 each  ALU opcode of requester n.
REQ-008 SHALL have ports rsp0_valid and rsp1_valid  output  1 each  result for requester n is held.
REQ-009 SHALL have ports rsp0_ready and rsp1_ready  input  1 each  requester n takes the result.
REQ-010 SHALL have port rsp_c  output  32  registered result, shared by both response ports.
REQ-011 SHALL have port rsp_zero  output  1  registered flag, 1 when rsp_c equals 0.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL instantiate exactly one alu and SHALL share it between the two requesters.
REQ-014 SHALL decode these opcodes: 000 pass A, 001 A+B, 010 A-B, 011 AND, 100 OR, 101 signed A<B, 110 unsigned A<B, 111 result 0.
REQ-015 SHALL produce 32-bit results with add and subtract wrapping modulo 2^32, and SHALL produce 1 or 0 for both compare opcodes.
REQ-016 SHALL implement a two-state FSM with states IDLE and RESP.
REQ-017 In IDLE with at least one reqN_valid, SHALL assert reqN_ready combinationally for exactly one granted port in the same cycle; the other port's ready SHALL stay low.
REQ-018 SHALL keep both reqN_ready signals low outside IDLE.
REQ-019 On an accepted request, SHALL drive the granted operands to the ALU, register C into rsp_c and the zero flag into rsp_zero at that edge, and move to RESP.
REQ-020 In RESP, SHALL set rspN_valid high for the granted port only, and SHALL hold rsp_c and rsp_zero stable.
REQ-021 Latency: a request accepted at edge k SHALL have its rspN_valid high from edge k onward, i.e. visible in cycle k+1.
REQ-022 In RESP, when rspN_valid and rspN_ready are both high, SHALL drop rspN_valid at the next edge and return to IDLE.
REQ-023 A new grant SHALL occur no earlier than the cycle after the return to IDLE; peak throughput is one operation per two cycles.
REQ-024 Round-robin: when both requests are valid, SHALL grant the port that did not win the last grant; after each grant the priority pointer SHALL flip to the other port.
REQ-025 With a single valid request, SHALL grant that port regardless of the pointer, and the pointer SHALL still update.
REQ-026 SHALL ignore rspN_ready for the non-granted port.
REQ-027 SHALL ignore changes on request inputs while in RESP.

Reset
REQ-028 When rst is high at an edge, SHALL force state to IDLE, rsp_c to 0, rsp_zero to 0, both rspN_valid to 0, and the pointer to GRANT_INIT, discarding any in-flight result.
REQ-029 While rst is high, SHALL hold both reqN_ready low, so that no request is accepted during reset.
REQ-030 busy SHALL be 0 in the first cycle after reset is released.

Configuration
REQ-031 When macro ALU_ARB_FIXED_PRIO_EN is defined, SHALL give port 0 priority on every simultaneous request and SHALL not implement the pointer, which makes GRANT_INIT unused.
REQ-032 When ALU_ARB_FIXED_PRIO_EN is undefined, SHALL apply the round-robin behaviour of REQ-024 and REQ-025.

Verification
REQ-033 SHALL pass the following: reset, then req0 only with op 001, a=7, b=-7 -> req0_ready in the same cycle, next cycle rsp0_valid=1, rsp_c=0, rsp_zero=1.
REQ-034 SHALL pass the following: req1 with op 110, a=32'hFFFFFFFF, b=1, and rsp1_ready low for 3 cycles -> rsp1_valid and rsp_c=0 held for all 3 cycles; then ready high -> valid drops the next cycle.
REQ-035 SHALL pass the following: both ports valid continuously with GRANT_INIT=0 and no macro -> grants in order 0, 1, 0, 1, with one grant every 2 cycles; with the macro defined -> every grant goes to port 0.
REQ-036 SHALL pass the following: op 101 with a=-1, b=1 -> rsp_c=1; op 110 with the same operands -> rsp_c=0; op 111 -> rsp_c=0 and rsp_zero=1.
REQ-037 SHALL pass the following: rst asserted for 1 cycle while in RESP with rsp0_valid=1 -> next cycle rsp0_valid=0, rsp_c=0, busy=0, and no response is ever delivered for that request.
REQ-038 SHALL pass the following: rsp1_ready held high while port 0 owns the response -> no effect on the FSM or on rsp0_valid.
